uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

Buffered UART transmitter on the 117.96 MHz UART clock domain (1024 × 115200 baud). It accepts bytes over a valid/ready stream, queues them in a small FIFO, and serialises each as an 8N1 frame on `io_tx`, or 8E1 when parity is enabled. It is the transmit-direction counterpart of the SoC's UART receive path, and its `io_tx` drives the board's `o_uart_tx` pin.

## Interface
- `CLOCKS_PER_BIT`, 1024, clock cycles per bit period; must be ≥ 2.
- `FIFO_DEPTH`, 8, byte entries; must be a power of two, ≥ 2.
- `clock`  in  1  UART clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high.
- `io_in_valid`  in  1  byte offered.
- `io_in_ready`  out  1  FIFO can accept a byte.
- `io_in_bits`  in  8  byte to send, LSB first.
- `io_tx`  out  1  serial line, idle high.
- `io_busy`  out  1  FIFO non-empty or frame in progress.
- `io_count`  out  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte being shifted.

## Operation
- Push: `io_in_valid && io_in_ready` at a clock edge writes `io_in_bits` to the FIFO.
- `io_in_ready` is `io_count != FIFO_DEPTH`.
  - When full, no push occurs, even if a pop happens in the same cycle. There is no full-bypass.
- The FSM has these states, in frame order:
  - IDLE: `io_tx` = 1. If the FIFO is non-empty, pop the head into the shift register, clear the bit counter and baud counter, and go to START.
  - START: `io_tx` = 0 for `CLOCKS_PER_BIT` cycles, then go to DATA.
  - DATA: `io_tx` = shift[0]. After each bit period, shift right and increment the bit index. After bit 7, go to PARITY if parity is enabled, otherwise to STOP.
  - PARITY: `io_tx` = XOR of the 8 data bits (even parity) for one bit period, then go to STOP.
  - STOP: `io_tx` = 1 for one bit period.
    - At the end of STOP, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- Baud counter: counts 0..`CLOCKS_PER_BIT`-1. The bit period ends on the cycle where the count equals `CLOCKS_PER_BIT`-1, and the counter wraps to 0 on that edge.
- Simultaneous push and pop when not full: `io_count` is unchanged and both operations take effect.
- Push while empty and IDLE: the byte is written on edge N, popped on edge N+1, and START begins.
- `io_count` width is $clog2(FIFO_DEPTH)+1 so it can represent the full value. Read and write pointers wrap modulo `FIFO_DEPTH`.
- `io_tx` is driven from a register, so the line never glitches.

## Timing
- Reset values:
  - `io_tx` = 1, `io_in_ready` = 1, `io_busy` = 0, `io_count` = 0.
  - FSM in IDLE, FIFO pointers 0, all counters 0.
- Reset mid-frame aborts the frame and discards all queued bytes. `io_tx` is 1 on the cycle after reset is asserted.
- Latency: a byte pushed on edge N into an empty, idle block drives `io_tx` low from edge N+1.
- Frame length is exactly 10 × `CLOCKS_PER_BIT` cycles, or 11 × `CLOCKS_PER_BIT` with parity.
- The start bit of a back-to-back frame begins exactly one frame length after the previous start bit.
- `io_busy` falls on the edge where the FSM enters IDLE with the FIFO empty.

## Configuration
- `UART_TX_PARITY_EN`
  - Defined: the PARITY state is compiled in, each frame carries one even-parity bit after bit 7, and the frame is 11 bit periods.
  - Undefined: PARITY logic is absent, DATA goes directly to STOP, and the frame is 10 bit periods.

## Test plan
- **Single byte.** `CLOCKS_PER_BIT`=16, push 0x55 into an idle block.
  - `io_tx` = 1 until edge N+1.
  - Then 16 cycles each of: 0 (start), 1,0,1,0,1,0,1,0, 1 (stop).
  - `io_busy` is high for 160 cycles.
- **Back-to-back.** Push 0xA3 then 0x0F on consecutive cycles.
  - The second start bit begins exactly 160 cycles after the first.
  - `io_tx` never idles high between the two frames beyond the stop bit.
- **Full FIFO.** `FIFO_DEPTH`=8. While frame 0 is shifting, push 9 more bytes with `io_in_valid` held high.
  - `io_count` reaches 8 and `io_in_ready` = 0; the 9th byte is held off.
  - The 9th byte is accepted only after the next pop.
  - All 10 bytes appear on `io_tx` in push order.
- **Reset mid-frame.** Assert `reset` during bit 3 of 0xFF with 3 bytes queued.
  - Next cycle: `io_tx` = 1, `io_count` = 0, `io_busy` = 0.
  - No further frames are sent.
- **Parity.** With `UART_TX_PARITY_EN` defined, send 0x07 then 0x03.
  - Parity bits are 1 and 0 respectively.
  - Each frame is 176 cycles at `CLOCKS_PER_BIT`=16.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: byte FIFO feeding an 8N1 serialiser (8E1 when UART_TX_PARITY_EN is defined).
// Bytes arrive on a valid/ready stream, queue in a small FIFO, and leave LSB first on io_tx.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after data bit 7.
module uart_tx_buffered #(
    parameter int CLOCKS_PER_BIT = 1024,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          io_in_valid,
    output logic                          io_in_ready,
    input  logic [7:0]                    io_in_bits,
    output logic                          io_tx,
    output logic                          io_busy,
    output logic [$clog2(FIFO_DEPTH):0]   io_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLOCKS_PER_BIT - 1);
    localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            tx_q, tx_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    logic push;
    logic pop;
    logic fifo_nonempty;
    logic bit_end;

    assign fifo_nonempty = (count_q != '0);
    assign bit_end       = (baud_q == BAUD_LAST);
    assign push          = io_in_valid && (count_q != COUNT_FULL);

    assign io_in_ready = (count_q != COUNT_FULL);
    assign io_tx       = tx_q;
    assign io_busy     = fifo_nonempty || (state_q != IDLE);
    assign io_count    = count_q;

    // Next-state logic: walk the frame one bit period at a time and pop the FIFO head at frame start.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end && (bit_idx_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: baud timing, shift register, bit index and FIFO bookkeeping driven by push/pop.
    always_comb begin
        baud_d    = (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        if (pop) begin
            shift_d   = mem_q[rd_ptr_q];
            bit_idx_d = 3'd0;
        end else if (state_q == DATA && bit_end) begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
        end
`ifdef UART_TX_PARITY_EN
        parity_d = pop ? ^mem_q[rd_ptr_q] : parity_q;
`endif
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end

    // Output logic: line level for the state being entered, so the registered io_tx lines up with it.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // State and control registers with synchronous reset; reset drops any frame and queued bytes.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // FIFO storage; contents need no reset because the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (push && !reset) mem_q[wr_ptr_q] <= io_in_bits;
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: randomized self-checking bench for uart_tx_buffered.
// A line-level UART receiver decodes io_tx into frames, compared against frames built from pushed bytes.
module tb_uart_tx_buffered;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clock = 1'b0;
    logic       reset;
    logic       io_in_valid;
    logic       io_in_ready;
    logic [7:0] io_in_bits;
    logic       io_tx;
    logic       io_busy;
    logic [3:0] io_count;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic [10:0] bits;
        int          start;
    } frame_t;

    frame_t      rx_q[$];
    bit          mon_en = 1'b0;
    bit          mon_active = 1'b0;
    int          mon_cnt;
    int          mon_start;
    logic [10:0] mon_bits;

    uart_tx_buffered #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .io_in_valid(io_in_valid),
        .io_in_ready(io_in_ready),
        .io_in_bits (io_in_bits),
        .io_tx      (io_tx),
        .io_busy    (io_busy),
        .io_count   (io_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Receiver model: find the start bit, then sample mid-bit for every bit of the frame.
    always @(negedge clock) begin
        if (!mon_en) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (io_tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                mon_bits   = '1;
                mon_start  = cyc;
            end
        end else begin
            mon_cnt++;
        end
        if (mon_en && mon_active && (mon_cnt % CPB) == CPB / 2) begin
            mon_bits[mon_cnt / CPB] = io_tx;
            if (mon_cnt / CPB == NBITS - 1) begin
                rx_q.push_back('{bits: mon_bits, start: mon_start});
                mon_active = 1'b0;
            end
        end
    end

    // Frame a byte is expected to produce: start 0, data LSB first, optional even parity, stop 1.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    task automatic push_one(input logic [7:0] b, output int edge_n, output bit ok);
        int w = 0;
        io_in_valid = 1'b1;
        io_in_bits  = b;
        while (io_in_ready !== 1'b1 && w < 2 * FRAME) begin
            @(negedge clock);
            w++;
        end
        ok     = (io_in_ready === 1'b1);
        edge_n = cyc + 1;
        @(negedge clock);
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        int w = 0;
        while (rx_q.size() < n && w < budget) begin
            @(negedge clock);
            w++;
        end
        ok = (rx_q.size() >= n);
    endtask

    task automatic wait_idle(output bit ok);
        int w = 0;
        while ((io_busy !== 1'b0 || mon_active) && w < 20 * FRAME) begin
            @(negedge clock);
            w++;
        end
        ok = (io_busy === 1'b0);
        repeat (2) @(negedge clock);
        rx_q.delete();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        io_in_valid = 1'b0;
        io_in_bits = 8'h00;
        repeat (3) @(negedge clock);
        n_checks++;
        if (io_tx !== 1'b1) $display("[TB] FAIL reset_tx got=%b exp=1", io_tx); else n_pass++;
        n_checks++;
        if (io_in_ready !== 1'b1) $display("[TB] FAIL reset_ready got=%b exp=1", io_in_ready); else n_pass++;
        n_checks++;
        if (io_busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b exp=0", io_busy); else n_pass++;
        n_checks++;
        if (io_count !== 4'd0) $display("[TB] FAIL reset_count got=%0d exp=0", io_count); else n_pass++;
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_single(input logic [7:0] b);
        int e;
        bit ok;
        bit bad_tx = 1'b0;
        bit bad_busy = 1'b0;
        logic [10:0] f;
        f = exp_frame(b);
        push_one(b, e, ok);
        io_in_valid = 1'b0;
        n_checks++;
        if (!ok) $display("[TB] FAIL single_push got=timeout exp=accepted"); else n_pass++;
        n_checks++;
        if (io_tx !== 1'b1) $display("[TB] FAIL single_pre_tx got=%b exp=1", io_tx); else n_pass++;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clock);
            if (io_tx !== f[i / CPB] && !bad_tx) begin
                bad_tx = 1'b1;
                $display("[TB] FAIL single_wave byte=%h cycle=%0d got=%b exp=%b", b, i, io_tx, f[i / CPB]);
            end
            if (io_busy !== 1'b1 && !bad_busy) begin
                bad_busy = 1'b1;
                $display("[TB] FAIL single_busy byte=%h cycle=%0d got=%b exp=1", b, i, io_busy);
            end
        end
        n_checks += 2;
        n_pass += (bad_tx ? 0 : 1) + (bad_busy ? 0 : 1);
        @(negedge clock);
        n_checks++;
        if (io_busy !== 1'b0 || io_tx !== 1'b1)
            $display("[TB] FAIL single_end got busy=%b tx=%b exp busy=0 tx=1", io_busy, io_tx);
        else n_pass++;
        wait_idle(ok);
    endtask

    task automatic test_back_to_back;
        int e0, e1;
        bit ok0, ok1, ok;
        push_one(8'hA3, e0, ok0);
        push_one(8'h0F, e1, ok1);
        io_in_valid = 1'b0;
        wait_frames(2, 3 * FRAME, ok);
        n_checks++;
        if (!(ok0 && ok1 && ok)) $display("[TB] FAIL b2b_frames got=%0d exp=2", rx_q.size());
        else begin
            n_pass++;
            n_checks++;
            if (rx_q[0].bits !== exp_frame(8'hA3)) $display("[TB] FAIL b2b_f0 got=%b exp=%b", rx_q[0].bits, exp_frame(8'hA3)); else n_pass++;
            n_checks++;
            if (rx_q[1].bits !== exp_frame(8'h0F)) $display("[TB] FAIL b2b_f1 got=%b exp=%b", rx_q[1].bits, exp_frame(8'h0F)); else n_pass++;
            n_checks++;
            if (rx_q[0].start !== e0 + 1) $display("[TB] FAIL b2b_latency got=%0d exp=%0d", rx_q[0].start, e0 + 1); else n_pass++;
            n_checks++;
            if (rx_q[1].start - rx_q[0].start !== FRAME)
                $display("[TB] FAIL b2b_spacing got=%0d exp=%0d", rx_q[1].start - rx_q[0].start, FRAME);
            else n_pass++;
        end
        wait_idle(ok);
    endtask

    task automatic test_full_fifo;
        logic [7:0] bytes [10];
        int e0, e;
        int w = 0;
        bit ok, all_ok = 1'b1;
        for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom);
        push_one(bytes[0], e0, ok);
        all_ok &= ok;
        for (int i = 1; i < 9; i++) begin
            push_one(bytes[i], e, ok);
            all_ok &= ok;
        end
        io_in_bits = bytes[9];
        n_checks++;
        if (!all_ok) $display("[TB] FAIL full_pushes got=timeout exp=accepted"); else n_pass++;
        n_checks++;
        if (io_count !== 4'd8) $display("[TB] FAIL full_count got=%0d exp=8", io_count); else n_pass++;
        n_checks++;
        if (io_in_ready !== 1'b0) $display("[TB] FAIL full_ready got=%b exp=0", io_in_ready); else n_pass++;
        while (io_in_ready !== 1'b1 && w < 2 * FRAME) begin
            @(negedge clock);
            w++;
        end
        n_checks++;
        if (cyc !== e0 + 1 + FRAME) $display("[TB] FAIL full_release got=%0d exp=%0d", cyc, e0 + 1 + FRAME); else n_pass++;
        n_checks++;
        if (io_count !== 4'd7) $display("[TB] FAIL full_after_pop got=%0d exp=7", io_count); else n_pass++;
        @(negedge clock);
        io_in_valid = 1'b0;
        n_checks++;
        if (io_count !== 4'd8) $display("[TB] FAIL full_refill got=%0d exp=8", io_count); else n_pass++;
        wait_frames(10, 11 * FRAME, ok);
        n_checks++;
        if (!ok) $display("[TB] FAIL full_frames got=%0d exp=10", rx_q.size());
        else begin
            n_pass++;
            for (int i = 0; i < 10; i++) begin
                n_checks++;
                if (rx_q[i].bits !== exp_frame(bytes[i]))
                    $display("[TB] FAIL full_order idx=%0d got=%b exp=%b", i, rx_q[i].bits, exp_frame(bytes[i]));
                else n_pass++;
            end
        end
        wait_idle(ok);
    endtask

    task automatic test_reset_mid_frame;
        int e0, e;
        bit ok, all_ok = 1'b1, stayed_idle = 1'b1;
        push_one(8'hFF, e0, ok);
        all_ok &= ok;
        for (int i = 0; i < 3; i++) begin
            push_one(8'($urandom), e, ok);
            all_ok &= ok;
        end
        io_in_valid = 1'b0;
        while (cyc < e0 + 1 + 4 * CPB + CPB / 2) @(negedge clock);
        n_checks++;
        if (!all_ok || io_count !== 4'd3) $display("[TB] FAIL rst_mid_queued got=%0d exp=3", io_count); else n_pass++;
        reset = 1'b1;
        mon_en = 1'b0;
        @(negedge clock);
        n_checks++;
        if (io_tx !== 1'b1 || io_count !== 4'd0 || io_busy !== 1'b0)
            $display("[TB] FAIL rst_mid_state got tx=%b count=%0d busy=%b exp tx=1 count=0 busy=0", io_tx, io_count, io_busy);
        else n_pass++;
        reset = 1'b0;
        rx_q.delete();
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clock);
            if (io_tx !== 1'b1 || io_busy !== 1'b0) stayed_idle = 1'b0;
        end
        n_checks++;
        if (!stayed_idle) $display("[TB] FAIL rst_mid_quiet got=activity exp=idle"); else n_pass++;
        mon_en = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_random_stream;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int e;
        bit ok, all_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            push_one(b, e, ok);
            all_ok &= ok;
            io_in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        wait_frames(12, 13 * FRAME, ok);
        n_checks++;
        if (!(ok && all_ok)) $display("[TB] FAIL rand_frames got=%0d exp=12", rx_q.size());
        else begin
            n_pass++;
            for (int i = 0; i < 12; i++) begin
                n_checks++;
                if (rx_q[i].bits !== exp_frame(exp_q[i]))
                    $display("[TB] FAIL rand_frame idx=%0d got=%b exp=%b", i, rx_q[i].bits, exp_frame(exp_q[i]));
                else n_pass++;
                if (i > 0) begin
                    n_checks++;
                    if (rx_q[i].start - rx_q[i - 1].start < FRAME)
                        $display("[TB] FAIL rand_spacing idx=%0d got=%0d exp>=%0d", i, rx_q[i].start - rx_q[i - 1].start, FRAME);
                    else n_pass++;
                end
            end
        end
        wait_idle(ok);
    endtask

    task automatic test_parity;
        int e0, e1;
        bit ok0, ok1, ok;
        push_one(8'h07, e0, ok0);
        push_one(8'h03, e1, ok1);
        io_in_valid = 1'b0;
        wait_frames(2, 3 * FRAME, ok);
        n_checks++;
        if (!(ok0 && ok1 && ok)) $display("[TB] FAIL par_frames got=%0d exp=2", rx_q.size());
        else begin
            n_pass++;
            n_checks++;
            if (rx_q[0].bits !== exp_frame(8'h07)) $display("[TB] FAIL par_f0 got=%b exp=%b", rx_q[0].bits, exp_frame(8'h07)); else n_pass++;
            n_checks++;
            if (rx_q[1].bits !== exp_frame(8'h03)) $display("[TB] FAIL par_f1 got=%b exp=%b", rx_q[1].bits, exp_frame(8'h03)); else n_pass++;
`ifdef UART_TX_PARITY_EN
            n_checks++;
            if (rx_q[0].bits[9] !== 1'b1 || rx_q[1].bits[9] !== 1'b0)
                $display("[TB] FAIL par_bits got=%b%b exp=10", rx_q[0].bits[9], rx_q[1].bits[9]);
            else n_pass++;
`endif
            n_checks++;
            if (rx_q[1].start - rx_q[0].start !== FRAME)
                $display("[TB] FAIL par_length got=%0d exp=%0d", rx_q[1].start - rx_q[0].start, FRAME);
            else n_pass++;
        end
        wait_idle(ok);
    endtask

    initial begin
        test_reset();
        test_single(8'h55);
        test_single(8'($urandom));
        test_back_to_back();
        test_full_fifo();
        test_reset_mid_frame();
        test_random_stream();
        test_parity();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
